// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle for pipe_hazard_ctrl: instruction/status inputs and latch controls.
// master = the hazard controller, slave = the pipeline datapath.
interface pipe_hazard_ctrl_if;
    logic [31:0] fd_ir;
    logic [31:0] dx_ir;
    logic        branch_taken;
    logic        md_ready;
    logic        pc_we;
    logic        fd_we;
    logic        fd_flush;
    logic        dx_we;
    logic        dx_flush;
    logic        xm_nop;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic        md_busy;
    logic        md_timeout;

    modport master (
        input  fd_ir, dx_ir, branch_taken, md_ready,
        output pc_we, fd_we, fd_flush, dx_we, dx_flush, xm_nop,
               md_ctrl_mult, md_ctrl_div, md_busy, md_timeout
    );

    modport slave (
        output fd_ir, dx_ir, branch_taken, md_ready,
        input  pc_we, fd_we, fd_flush, dx_we, dx_flush, xm_nop,
               md_ctrl_mult, md_ctrl_div, md_busy, md_timeout
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch flush, mult/div sequencing.
// Define HAZARD_STATS_EN to add stall_cycles/flush_count statistics outputs.
module pipe_hazard_ctrl #(
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 7
) (
    input  logic                 clock,
    input  logic                 clear,
`ifdef HAZARD_STATS_EN
    output logic [31:0]          stall_cycles,
    output logic [31:0]          flush_count,
`endif
    pipe_hazard_ctrl_if.master   bus
);

    typedef enum logic {IDLE, MD_WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             timeout_q;

    logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
    logic [4:0] dx_op, dx_rd, dx_aluop;
    logic       is_mult, is_div, md_op;
    logic       fd_reads_rd, load_use, timeout_hit;

    assign fd_op    = bus.fd_ir[31:27];
    assign fd_rd    = bus.fd_ir[26:22];
    assign fd_rs    = bus.fd_ir[21:17];
    assign fd_rt    = bus.fd_ir[16:12];
    assign dx_op    = bus.dx_ir[31:27];
    assign dx_rd    = bus.dx_ir[26:22];
    assign dx_aluop = bus.dx_ir[6:2];

    assign is_mult = (dx_op == 5'b00000) && (dx_aluop == 5'b00110);
    assign is_div  = (dx_op == 5'b00000) && (dx_aluop == 5'b00111);
    assign md_op   = is_mult || is_div;

    // dx_rd is known non-zero when load_use is evaluated, so register 0 can never match.
    always_comb begin
        fd_reads_rd = 1'b0;
        case (fd_op)
            5'b00000:                   fd_reads_rd = (fd_rs == dx_rd) || (fd_rt == dx_rd);
            5'b00101, 5'b01000:         fd_reads_rd = (fd_rs == dx_rd);
            5'b00111, 5'b00010,
            5'b00110:                   fd_reads_rd = (fd_rd == dx_rd) || (fd_rs == dx_rd);
            5'b00100:                   fd_reads_rd = (fd_rd == dx_rd);
            5'b10110:                   fd_reads_rd = (dx_rd == 5'd30);
            default:                    fd_reads_rd = 1'b0;
        endcase
    end

    assign load_use    = (dx_op == 5'b01000) && (dx_rd != 5'd0) && fd_reads_rd;
    assign timeout_hit = (count == CNT_W'(MD_TIMEOUT - 1));

    always_comb begin
        bus.pc_we        = 1'b1;
        bus.fd_we        = 1'b1;
        bus.fd_flush     = 1'b0;
        bus.dx_we        = 1'b1;
        bus.dx_flush     = 1'b0;
        bus.xm_nop       = 1'b0;
        bus.md_ctrl_mult = 1'b0;
        bus.md_ctrl_div  = 1'b0;
        bus.md_busy      = 1'b0;
        bus.md_timeout   = 1'b0;
        if (!clear) begin
            bus.md_timeout = timeout_q;
            case (state)
                IDLE: begin
                    if (bus.branch_taken) begin
                        bus.fd_flush = 1'b1;
                        bus.dx_flush = 1'b1;
                    end else if (md_op) begin
                        bus.md_ctrl_mult = is_mult;
                        bus.md_ctrl_div  = is_div;
                        bus.pc_we        = 1'b0;
                        bus.fd_we        = 1'b0;
                        bus.dx_we        = 1'b0;
                        bus.xm_nop       = 1'b1;
                    end else if (load_use) begin
                        bus.pc_we    = 1'b0;
                        bus.fd_we    = 1'b0;
                        bus.dx_flush = 1'b1;
                    end
                end
                MD_WAIT: begin
                    bus.md_busy = 1'b1;
                    if (!bus.md_ready && !timeout_hit) begin
                        bus.pc_we  = 1'b0;
                        bus.fd_we  = 1'b0;
                        bus.dx_we  = 1'b0;
                        bus.xm_nop = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= IDLE;
            count     <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.branch_taken && md_op) begin
                        state <= MD_WAIT;
                        count <= '0;
                    end
                end
                MD_WAIT: begin
                    if (bus.md_ready) begin
                        state <= IDLE;
                    end else if (timeout_hit) begin
                        state     <= IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clock) begin
        if (clear) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!bus.pc_we)   stall_cycles <= stall_cycles + 32'd1;
            if (bus.fd_flush) flush_count  <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver queues expected outputs, monitor compares mid-cycle.
module tb_pipe_hazard_ctrl;

    logic clock = 1'b0;
    logic clear = 1'b1;
    always #5 clock = ~clock;

    pipe_hazard_ctrl_if ifc ();

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    pipe_hazard_ctrl #(.MD_TIMEOUT(64), .CNT_W(7)) dut (
        .clock        (clock),
        .clear        (clear),
`ifdef HAZARD_STATS_EN
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
`endif
        .bus          (ifc)
    );

    typedef struct {
        logic [9:0] exp;
        string      tag;
    } sb_t;

    sb_t sbq[$];
    int  checks = 0;
    int  errors = 0;

    // Vector: {pc_we, fd_we, fd_flush, dx_we, dx_flush, xm_nop, mult, div, busy, timeout}
    function automatic logic [9:0] mk(input logic pc, fdw, fdf, dxw, dxf, xm, mu, dv, bsy, to);
        return {pc, fdw, fdf, dxw, dxf, xm, mu, dv, bsy, to};
    endfunction

    function automatic logic [9:0] v_def(input logic to);   return mk(1,1,0,1,0,0,0,0,0,to); endfunction
    function automatic logic [9:0] v_lu(input logic to);    return mk(0,0,0,1,1,0,0,0,0,to); endfunction
    function automatic logic [9:0] v_br(input logic to);    return mk(1,1,1,1,1,0,0,0,0,to); endfunction
    function automatic logic [9:0] v_mul(input logic to);   return mk(0,0,0,0,0,1,1,0,0,to); endfunction
    function automatic logic [9:0] v_div(input logic to);   return mk(0,0,0,0,0,1,0,1,0,to); endfunction
    function automatic logic [9:0] v_wait(input logic to);  return mk(0,0,0,0,0,1,0,0,1,to); endfunction
    function automatic logic [9:0] v_rel(input logic to);   return mk(1,1,0,1,0,0,0,0,1,to); endfunction

    function automatic logic [31:0] r_i(input logic [4:0] rd, rs, rt, alu);
        return {5'd0, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction
    function automatic logic [31:0] i_i(input logic [4:0] op, rd, rs);
        return {op, rd, rs, 17'd0};
    endfunction

    localparam logic [31:0] NOP = 32'd0;

    task automatic step(input logic [31:0] fd, dx, input logic br, rdy, clr,
                        input logic [9:0] e, input string tag);
        sb_t item;
        @(posedge clock);
        #1;
        ifc.fd_ir        = fd;
        ifc.dx_ir        = dx;
        ifc.branch_taken = br;
        ifc.md_ready     = rdy;
        clear            = clr;
        item.exp = e;
        item.tag = tag;
        sbq.push_back(item);
    endtask

    always @(negedge clock) begin
        if (sbq.size() > 0) begin
            sb_t        item;
            logic [9:0] got;
            item = sbq.pop_front();
            got  = {ifc.pc_we, ifc.fd_we, ifc.fd_flush, ifc.dx_we, ifc.dx_flush,
                    ifc.xm_nop, ifc.md_ctrl_mult, ifc.md_ctrl_div, ifc.md_busy, ifc.md_timeout};
            checks++;
            if (got !== item.exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b at %0t", item.tag, got, item.exp, $time);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] lw3, mul, dv, add_rs3;
        lw3     = i_i(5'b01000, 5'd3, 5'd1);
        mul     = r_i(5'd1, 5'd2, 5'd3, 5'b00110);
        dv      = r_i(5'd6, 5'd7, 5'd8, 5'b00111);
        add_rs3 = r_i(5'd5, 5'd3, 5'd4, 5'b00000);

        ifc.fd_ir = NOP; ifc.dx_ir = NOP; ifc.branch_taken = 1'b0; ifc.md_ready = 1'b0;

        step(NOP, NOP, 0, 0, 1, v_def(0), "reset0");
        step(NOP, NOP, 0, 0, 1, v_def(0), "reset1");
        step(NOP, NOP, 0, 0, 0, v_def(0), "idle");

        // Load-use detection across source-field variants
        step(add_rs3, lw3, 0, 0, 0, v_lu(0),  "lu_rtype_rs");
        step(add_rs3, NOP, 0, 0, 0, v_def(0), "lu_cleared");
        step(r_i(5'd5, 5'd4, 5'd3, 5'd0), lw3, 0, 0, 0, v_lu(0), "lu_rtype_rt");
        step(r_i(5'd5, 5'd0, 5'd0, 5'd0), i_i(5'b01000, 5'd0, 5'd1), 0, 0, 0, v_def(0), "lu_r0");
        step(i_i(5'b00111, 5'd3, 5'd9), lw3, 0, 0, 0, v_lu(0),  "lu_sw_rd");
        step(i_i(5'b00101, 5'd5, 5'd3), lw3, 0, 0, 0, v_lu(0),  "lu_addi_rs");
        step(i_i(5'b00101, 5'd3, 5'd4), lw3, 0, 0, 0, v_def(0), "lu_addi_rd_not_src");
        step(i_i(5'b10110, 5'd0, 5'd0), i_i(5'b01000, 5'd30, 5'd1), 0, 0, 0, v_lu(0), "lu_bex_r30");
        step(i_i(5'b00001, 5'd3, 5'd3), lw3, 0, 0, 0, v_def(0), "lu_j_nosrc");
        step(i_i(5'b00100, 5'd3, 5'd0), lw3, 0, 0, 0, v_lu(0),  "lu_jr_rd");
        step(i_i(5'b00010, 5'd9, 5'd3), lw3, 0, 0, 0, v_lu(0),  "lu_bne_rs");

        // Branch flush wins over load-use
        step(add_rs3, lw3, 1, 0, 0, v_br(0),  "branch_over_lu");
        step(NOP, NOP, 0, 0, 0, v_def(0), "post_branch");

        // mult: pulse, 16 wait cycles, release on the 17th cycle after the pulse
        step(NOP, mul, 0, 0, 0, v_mul(0), "mul_pulse");
        for (int unsigned i = 1; i <= 16; i++)
            step(NOP, mul, (i == 4), 0, 0, v_wait(0), $sformatf("mul_wait%0d", i));
        step(NOP, mul, 0, 1, 0, v_rel(0), "mul_release");
        step(NOP, NOP, 0, 1, 0, v_def(0), "mul_idle_ready_ignored");

        // div timeout: pulse + 63 wait stalls = 64 stall cycles, release on count==63
        step(NOP, dv, 0, 0, 0, v_div(0), "div_pulse");
        for (int unsigned i = 1; i <= 63; i++)
            step(NOP, dv, 0, 0, 0, v_wait(0), $sformatf("div_wait%0d", i));
        step(NOP, dv, 0, 0, 0, v_rel(0), "div_forced_release");
        step(NOP, NOP, 0, 0, 0, v_def(1), "timeout_sticky0");
        step(add_rs3, lw3, 0, 0, 0, v_lu(1), "timeout_sticky_lu");
        step(NOP, NOP, 0, 0, 0, v_def(1), "timeout_sticky1");

        // Back-to-back md ops
        step(NOP, mul, 0, 0, 0, v_mul(1), "b2b_mul_pulse");
        step(NOP, mul, 0, 1, 0, v_rel(1), "b2b_mul_release");
        step(NOP, dv, 0, 0, 0, v_div(1), "b2b_div_pulse");
        step(NOP, dv, 0, 1, 0, v_rel(1), "b2b_div_release");
        step(NOP, NOP, 0, 0, 0, v_def(1), "b2b_idle");

        // Clear during MD_WAIT
        step(NOP, mul, 0, 0, 0, v_mul(1), "clr_mul_pulse");
        for (int unsigned i = 1; i <= 4; i++)
            step(NOP, mul, 0, 0, 0, v_wait(1), $sformatf("clr_wait%0d", i));
        step(NOP, mul, 0, 0, 1, v_def(0), "clr_in_wait");
        step(NOP, NOP, 0, 0, 0, v_def(0), "clr_after_idle");
        step(NOP, mul, 0, 0, 0, v_mul(0), "clr_new_pulse");
        step(NOP, mul, 0, 1, 0, v_rel(0), "clr_new_release");
        step(NOP, NOP, 0, 0, 0, v_def(0), "final_idle");

`ifdef HAZARD_STATS_EN
        step(NOP, NOP, 0, 0, 1, v_def(0), "stats_reset");
        step(add_rs3, lw3, 0, 0, 0, v_lu(0), "stats_lu");
        step(NOP, NOP, 1, 0, 0, v_br(0), "stats_br");
        step(NOP, NOP, 0, 0, 0, v_def(0), "stats_idle");
        #1;
        checks++;
        if (stall_cycles !== 32'd1) begin
            errors++;
            $display("FAIL stall_cycles: got %0d expected 1", stall_cycles);
        end
        checks++;
        if (flush_count !== 32'd1) begin
            errors++;
            $display("FAIL flush_count: got %0d expected 1", flush_count);
        end
`endif

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clock);
        if (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
